// File: rtl/data.sv
// Shared types for the obstacle collision checker: obstacle slot layout,
// hitbox constant and the two FSM state encodings.
package data;

  localparam int OBSTACLE_WIDTH = 16;
  localparam int NUM_SLOTS      = 10;

  typedef struct packed {
    logic        active;
    logic [1:0]  lane;
    logic [10:0] position;
    logic [1:0]  sprite_type;
  } obstacle_t;

  typedef enum logic {
    GROUND,
    AIRBORNE
  } jump_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } scan_state_t;

endpackage

// File: rtl/player_jump_fsm.sv
// Player jump state: a jump request launches a JUMP_FRAMES-long airborne
// phase that counts down on every video frame.
module player_jump_fsm
  import data::*;
#(
  parameter int JUMP_FRAMES = 24
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic game_reset,
  input  logic frame_trigger,
  input  logic jump_in,
  output logic airborne
);

  localparam int CW = $clog2(JUMP_FRAMES + 1);

  jump_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= GROUND;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (game_reset) begin
      state_nxt = GROUND;
      cnt_nxt   = '0;
    end else begin
      case (state)
        GROUND: if (jump_in) begin
          state_nxt = AIRBORNE;
          cnt_nxt   = CW'(JUMP_FRAMES);
        end
        AIRBORNE: if (frame_trigger) begin
          // Landing happens on the trigger that would take the count to zero
          if (cnt <= CW'(1)) begin
            state_nxt = GROUND;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        default: begin
          state_nxt = GROUND;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign airborne = (state == AIRBORNE);

endmodule

// File: rtl/obstacle_collision_checker.sv
// Per-frame sequential scan of the obstacle table against the player hitbox;
// latches the first hit of a game and flags frames that arrive mid-scan.
module obstacle_collision_checker
  import data::*;
#(
  parameter int PLAYER_X     = 64,
  parameter int PLAYER_WIDTH = 32,
  parameter int JUMP_FRAMES  = 24
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       game_reset,
  input  logic                       frame_trigger,
  input  logic                       jump_in,
  input  logic [1:0]                 lane_in,
  input  obstacle_t [NUM_SLOTS-1:0]  obstacles_in,
  output logic                       collision_out,
  output logic                       game_over_out,
  output logic [3:0]                 hit_index_out,
  output logic                       airborne_out,
  output logic                       busy_out,
  output logic                       scan_overrun_out
);

  localparam logic [11:0] HIT_LO = 12'(PLAYER_X);
  localparam logic [11:0] HIT_HI = 12'(PLAYER_X + PLAYER_WIDTH + OBSTACLE_WIDTH);
  localparam logic [3:0]  LAST   = 4'(NUM_SLOTS - 1);

  scan_state_t state, state_nxt;
  logic [3:0]  idx;
  logic [1:0]  snap_lane;
  logic        snap_air;
  logic        found;
  logic [3:0]  hit_idx_q;
  obstacle_t   cur;
  logic [11:0] pos12;
  logic        slot_hit;

  player_jump_fsm #(.JUMP_FRAMES(JUMP_FRAMES)) u_jump (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .game_reset    (game_reset),
    .frame_trigger (frame_trigger),
    .jump_in       (jump_in),
    .airborne      (airborne_out)
  );

  assign cur      = obstacles_in[idx];
  assign pos12    = {1'b0, cur.position};
  // Sprite types below 2 can be cleared by a jump
  assign slot_hit = cur.active && (cur.lane == snap_lane) &&
                    (pos12 > HIT_LO) && (pos12 < HIT_HI) &&
                    !(snap_air && (cur.sprite_type < 2'd2));

  assign busy_out      = (state != IDLE);
  assign collision_out = (state == REPORT) && found && !game_over_out && !game_reset;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_trigger) state_nxt = SCAN;
      SCAN:    if (idx == LAST)   state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (game_reset) state_nxt = IDLE;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx              <= '0;
      snap_lane        <= '0;
      snap_air         <= 1'b0;
      found            <= 1'b0;
      hit_idx_q        <= 4'hF;
      game_over_out    <= 1'b0;
      hit_index_out    <= 4'hF;
      scan_overrun_out <= 1'b0;
    end else if (game_reset) begin
      idx              <= '0;
      snap_lane        <= '0;
      snap_air         <= 1'b0;
      found            <= 1'b0;
      hit_idx_q        <= 4'hF;
      game_over_out    <= 1'b0;
      hit_index_out    <= 4'hF;
      scan_overrun_out <= 1'b0;
    end else begin
      if (state == IDLE && frame_trigger) begin
        idx       <= '0;
        found     <= 1'b0;
        hit_idx_q <= 4'hF;
        snap_lane <= lane_in;
        snap_air  <= airborne_out;
      end
      if (state == SCAN) begin
        if (idx != LAST) idx <= idx + 4'd1;
        if (slot_hit && !found) begin
          found     <= 1'b1;
          hit_idx_q <= idx;
        end
      end
      if (collision_out) begin
        game_over_out <= 1'b1;
        hit_index_out <= hit_idx_q;
      end
      if (busy_out && frame_trigger) scan_overrun_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obstacle_collision_checker.sv
// Directed bench for obstacle_collision_checker with hand-computed results.
// Default hitbox: hit when 64 < position < 112.
module tb_obstacle_collision_checker;
  import data::*;

  logic clk_in = 1'b0;
  logic rst_n_in, game_reset, frame_trigger, jump_in;
  logic [1:0] lane_in;
  obstacle_t [9:0] obs;
  logic collision_out, game_over_out, airborne_out, busy_out, scan_overrun_out;
  logic [3:0] hit_index_out;
  int errs = 0;
  int checks = 0;

  obstacle_collision_checker dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .game_reset       (game_reset),
    .frame_trigger    (frame_trigger),
    .jump_in          (jump_in),
    .lane_in          (lane_in),
    .obstacles_in     (obs),
    .collision_out    (collision_out),
    .game_over_out    (game_over_out),
    .hit_index_out    (hit_index_out),
    .airborne_out     (airborne_out),
    .busy_out         (busy_out),
    .scan_overrun_out (scan_overrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_slot(input int s, input int lane, input int pos, input int spr);
    obs[s] = {1'b1, 2'(lane), 11'(pos), 2'(spr)};
  endtask

  task automatic do_greset();
    game_reset = 1'b1;
    @(negedge clk_in);
    game_reset = 1'b0;
  endtask

  task automatic pulse_jump();
    jump_in = 1'b1;
    @(negedge clk_in);
    jump_in = 1'b0;
  endtask

  // Launch one frame (optionally with a simultaneous jump) and watch the scan.
  // Cycle j of the loop is cycle k+j relative to the sampling edge k.
  task automatic do_frame(input string tag, input logic exp_hit, input logic with_jump);
    int pulses, at;
    frame_trigger = 1'b1;
    jump_in = with_jump;
    @(negedge clk_in);
    frame_trigger = 1'b0;
    jump_in = 1'b0;
    pulses = 0;
    at = -1;
    for (int j = 1; j <= 13; j++) begin
      if (collision_out) begin
        pulses++;
        at = j;
      end
      @(negedge clk_in);
    end
    chk({tag, "_pulses"}, pulses, exp_hit ? 1 : 0);
    if (exp_hit) chk({tag, "_cycle"}, at, 11);
  endtask

  initial begin
    int pulses;
    rst_n_in = 1'b0; game_reset = 1'b0; frame_trigger = 1'b0; jump_in = 1'b0;
    lane_in = 2'd1; obs = '0;
    #12;
    chk("rst_col", collision_out, 0);
    chk("rst_go", game_over_out, 0);
    chk("rst_idx", hit_index_out, 4'hF);
    chk("rst_air", airborne_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_ovr", scan_overrun_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Basic hit in slot 3, ground, sprite 2
    set_slot(3, 1, 84, 2);
    frame_trigger = 1'b1;
    @(negedge clk_in);
    frame_trigger = 1'b0;
    chk("busy_scan", busy_out, 1);
    @(negedge clk_in);
    do_greset();
    chk("gr_busy", busy_out, 0);
    do_frame("basic", 1'b1, 1'b0);
    chk("basic_go", game_over_out, 1);
    chk("basic_idx", hit_index_out, 3);
    chk("basic_busy", busy_out, 0);

    // Other lane: no hit
    do_greset();
    chk("gr_idx", hit_index_out, 4'hF);
    lane_in = 2'd2;
    do_frame("lane", 1'b0, 1'b0);
    chk("lane_go", game_over_out, 0);
    lane_in = 2'd1;

    // Jumpable sprite cleared by jump, unjumpable one still hits
    obs = '0;
    pulse_jump();
    chk("jump_air", airborne_out, 1);
    do_frame("air_f1", 1'b0, 1'b0);
    do_frame("air_f2", 1'b0, 1'b0);
    set_slot(3, 1, 84, 0);
    do_frame("jump_s0", 1'b0, 1'b0);
    set_slot(3, 1, 84, 3);
    do_frame("jump_s3", 1'b1, 1'b0);
    chk("jump_s3_idx", hit_index_out, 3);

    // Jump and frame together: snapshot is grounded, so sprite 0 hits
    do_greset();
    chk("gr_air", airborne_out, 0);
    set_slot(3, 1, 84, 0);
    do_frame("coinc", 1'b1, 1'b1);
    chk("coinc_air", airborne_out, 1);

    // Two hits: lowest index wins, later frames don't pulse again
    do_greset();
    obs = '0;
    set_slot(2, 1, 100, 2);
    set_slot(7, 1, 70, 3);
    do_frame("two", 1'b1, 1'b0);
    chk("two_idx", hit_index_out, 2);
    set_slot(2, 1, 90, 2);
    set_slot(0, 1, 90, 2);
    do_frame("two_next", 1'b0, 1'b0);
    chk("two_next_idx", hit_index_out, 2);
    chk("two_next_go", game_over_out, 1);

    // Hitbox boundaries: exclusive on both ends
    obs = '0;
    do_greset(); set_slot(5, 1, 64, 2);  do_frame("b64", 1'b0, 1'b0);
    do_greset(); set_slot(5, 1, 65, 2);  do_frame("b65", 1'b1, 1'b0);
    chk("b65_idx", hit_index_out, 5);
    do_greset(); set_slot(5, 1, 111, 2); do_frame("b111", 1'b1, 1'b0);
    do_greset(); set_slot(5, 1, 112, 2); do_frame("b112", 1'b0, 1'b0);
    chk("b112_idx", hit_index_out, 4'hF);

    // Overrun: second trigger at k+5 dropped but still counts toward landing
    do_greset();
    obs = '0;
    set_slot(4, 1, 80, 2);
    pulse_jump();
    frame_trigger = 1'b1;
    @(negedge clk_in);
    frame_trigger = 1'b0;
    repeat (4) @(negedge clk_in);
    chk("ovr_pre", scan_overrun_out, 0);
    frame_trigger = 1'b1;
    @(negedge clk_in);
    frame_trigger = 1'b0;
    chk("ovr_set", scan_overrun_out, 1);
    pulses = 0;
    for (int j = 0; j < 20; j++) begin
      if (collision_out) pulses++;
      @(negedge clk_in);
    end
    chk("ovr_pulses", pulses, 1);
    chk("ovr_idx", hit_index_out, 4);
    for (int f = 0; f < 21; f++) begin
      frame_trigger = 1'b1;
      @(negedge clk_in);
      frame_trigger = 1'b0;
      repeat (2) @(negedge clk_in);
    end
    chk("land_23", airborne_out, 1);
    frame_trigger = 1'b1;
    @(negedge clk_in);
    frame_trigger = 1'b0;
    chk("land_24", airborne_out, 0);
    repeat (14) @(negedge clk_in);

    // Async reset in cycle k+6 of a hitting scan
    do_greset();
    pulse_jump();
    frame_trigger = 1'b1;
    @(negedge clk_in);
    frame_trigger = 1'b1;
    @(negedge clk_in);
    frame_trigger = 1'b0;
    repeat (4) @(negedge clk_in);
    chk("ar_busy_pre", busy_out, 1);
    chk("ar_ovr_pre", scan_overrun_out, 1);
    #2 rst_n_in = 1'b0;
    #1;
    chk("ar_busy", busy_out, 0);
    chk("ar_ovr", scan_overrun_out, 0);
    chk("ar_air", airborne_out, 0);
    chk("ar_idx", hit_index_out, 4'hF);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    pulses = 0;
    for (int j = 0; j < 16; j++) begin
      if (collision_out) pulses++;
      @(negedge clk_in);
    end
    chk("ar_pulses", pulses, 0);
    chk("ar_go", game_over_out, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
